// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with a small byte FIFO.
//   BASE_ADDR+0 : write pushes wdata[7:0] into the transmit FIFO
//   BASE_ADDR+4 : write clears ovf; read returns the status word
// Frame: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Compile-time option: define UART_TX_PARITY_EN to insert the parity bit
// (11-bit frame); without it the frame is 10 bits.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0]   DATA_ADDR = BASE_ADDR;
  localparam logic [31:0]   STAT_ADDR = BASE_ADDR + 32'd4;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, empty, ovf;
  logic          wr_data, wr_stat, push, pop;

  logic [2:0]    state;
  logic [CW-1:0] baud;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          baud_done;
  logic [3:0]    cnt4;
  logic          unused;

`ifdef UART_TX_PARITY_EN
  logic          par_bit;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  assign unused    = ^wdata[31:8];
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign wr_data   = we && (addr == DATA_ADDR);
  assign wr_stat   = we && (addr == STAT_ADDR);
  assign baud_done = (baud == BAUD_LAST);
  assign busy      = (state != IDLE);

  // The FIFO head leaves either from IDLE or at the last cycle of STOP so
  // that back-to-back frames have no idle gap.
  assign pop  = !empty && ((state == IDLE) || ((state == STOP) && baud_done));
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push = wr_data && (!full || pop);

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_data && full && !pop) ovf <= 1'b1;
      else if (wr_stat)            ovf <= 1'b0;
    end
  end

  // Shift register and parity capture: loaded on pop, shifted per data bit
  always_ff @(posedge clk) begin
    if (pop) begin
      shreg <= mem[rptr];
`ifdef UART_TX_PARITY_EN
      par_bit <= even_parity(mem[rptr]);
`endif
    end else if ((state == DATA) && baud_done) begin
      shreg <= shreg >> 1;
    end
  end

  // Frame FSM; tx is registered and set to the level of the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      baud   <= '0;
      bitcnt <= '0;
      tx     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud   <= '0;
          bitcnt <= '0;
          tx     <= 1'b1;
          if (pop) begin
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud  <= '0;
            state <= DATA;
            tx    <= shreg[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bitcnt == 3'd7) begin
              bitcnt <= '0;
`ifdef UART_TX_PARITY_EN
              state  <= PARITY;
              tx     <= par_bit;
`else
              state  <= STOP;
              tx     <= 1'b1;
`endif
            end else begin
              bitcnt <= bitcnt + 3'd1;
              tx     <= shreg[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud  <= '0;
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            baud <= baud + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            baud <= '0;
            if (pop) begin
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          baud   <= '0;
          bitcnt <= '0;
          tx     <= 1'b1;
        end
      endcase
    end
  end

  // Status read mux; every other address reads as zero
  always_comb begin
    cnt4  = 4'(count);
    rdata = '0;
    if (addr == STAT_ADDR) rdata = {23'b0, cnt4, 1'b0, ovf, busy, empty, full};
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: random payloads, reference frames
// built from the serial format (start, data LSB first, [parity], stop).
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam logic [31:0] STAT  = BASE + 32'd4;
  localparam int          CPB   = 16;
  localparam int          DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int          FB    = 11;
`else
  localparam int          FB    = 10;
`endif
  localparam int          L     = FB * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic       rec = 1'b0;
  logic       tx_log[$];
  logic       busy_log[$];
  logic [7:0] exp_q[$];

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rec) begin
      #1;
      tx_log.push_back(tx);
      busy_log.push_back(busy);
    end
  end

  // Line level expected k cycles into the frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    int bi;
    bi = k / CPB;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[bi-1];
`ifdef UART_TX_PARITY_EN
    if (bi == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic read_status(output logic [31:0] v);
    addr = STAT;
    #1;
    v = rdata;
    addr = '0;
  endtask

  task automatic start_rec();
    tx_log.delete();
    busy_log.delete();
    rec = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_accept);
    if (expect_accept) exp_q.push_back(b);
    write(BASE, {24'($urandom), b});
  endtask

  task automatic check_stream(input string tag);
    int n, zeros, bcnt, bfirst, blast;
    logic [L-1:0] o, e;
    n = exp_q.size();
    checks++;
    if (tx_log.size() < n*L + 2) begin
      errors++;
      $display("FAIL %s log_len got %0d need %0d", tag, tx_log.size(), n*L + 2);
    end else begin
      for (int f = 0; f < n; f++) begin
        for (int k = 0; k < L; k++) begin
          o[k] = tx_log[1 + f*L + k];
          e[k] = exp_bit(exp_q[f], k);
        end
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL %s frame%0d byte %02h got %h want %h", tag, f, exp_q[f], o, e);
        end
      end
      zeros = 0;
      if (tx_log[0] !== 1'b1) zeros++;
      for (int i = 1 + n*L; i < tx_log.size(); i++) if (tx_log[i] !== 1'b1) zeros++;
      checks++;
      if (zeros != 0) begin
        errors++;
        $display("FAIL %s idle_level got %0d low samples want 0", tag, zeros);
      end
      bcnt = 0; bfirst = -1; blast = -1;
      for (int i = 0; i < busy_log.size(); i++) begin
        if (busy_log[i] === 1'b1) begin
          bcnt++;
          if (bfirst < 0) bfirst = i;
          blast = i;
        end
      end
      checks++;
      if (bcnt != n*L) begin
        errors++;
        $display("FAIL %s busy_cycles got %0d want %0d", tag, bcnt, n*L);
      end
      checks++;
      if (bfirst != 1 || blast != n*L) begin
        errors++;
        $display("FAIL %s busy_window got %0d..%0d want 1..%0d", tag, bfirst, blast, n*L);
      end
    end
    exp_q.delete();
  endtask

  task automatic check_status(input string tag, input logic [31:0] want);
    logic [31:0] v;
    read_status(v);
    checks++;
    if (v !== want) begin
      errors++;
      $display("FAIL %s status got %08h want %08h", tag, v, want);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    check_status("reset_in", 32'h0000_0002);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL post_reset_tx got %b want 1", tx); end
    check_status("reset_out", 32'h0000_0002);
    addr = BASE ^ {20'($urandom), 12'h0} ^ 32'h0000_0010;
    #1;
    v = rdata;
    addr = '0;
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL other_addr_rdata got %08h want 0", v); end
  endtask

  task automatic test_single(input logic [7:0] b, input string tag);
    start_rec();
    send_byte(b, 1'b1);
    repeat (L + 8) @(posedge clk);
    #2;
    rec = 1'b0;
    check_stream(tag);
    check_status({tag, "_idle"}, 32'h0000_0002);
  endtask

  task automatic test_back_to_back();
    start_rec();
    send_byte(8'hA0, 1'b1);
    send_byte(8'h0F, 1'b1);
    repeat (2*L + 8) @(posedge clk);
    #2;
    rec = 1'b0;
    check_stream("back_to_back");
  endtask

  task automatic test_overflow();
    // The first byte moves to the shift register one edge after it lands,
    // so a burst can place DEPTH+1 bytes before anything is dropped.
    start_rec();
    for (int i = 0; i < 10; i++) send_byte(8'(i), i < DEPTH + 1);
    check_status("ovf_burst", {23'b0, 4'(DEPTH), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
    repeat ((DEPTH + 1)*L + 8) @(posedge clk);
    #2;
    rec = 1'b0;
    check_stream("overflow");
    check_status("ovf_sticky", 32'h0000_000A);
  endtask

  task automatic test_ovf_clear();
    write(STAT, $urandom);
    check_status("ovf_clear", 32'h0000_0002);
  endtask

  task automatic test_full_push_pop();
    // Fill FIFO (write edges E..E+8); the first pop after that is at E+1+L.
    start_rec();
    for (int i = 0; i < DEPTH + 1; i++) send_byte(8'($urandom), 1'b1);
    check_status("fill", {23'b0, 4'(DEPTH), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    repeat (L - 9) @(posedge clk);
    send_byte(8'($urandom), 1'b0);  // lands at E+L: still full, dropped
    send_byte(8'($urandom), 1'b1);  // lands at E+L+1 with the pop: accepted
    check_status("push_pop_full", {23'b0, 4'(DEPTH), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
    repeat ((DEPTH + 2)*L) @(posedge clk);
    #2;
    rec = 1'b0;
    check_stream("full_push_pop");
    write(STAT, 32'h0);
    check_status("ovf_clear2", 32'h0000_0002);
  endtask

  task automatic test_reset_midframe();
    int lows, bsy;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
    // writes at E..E+3, frame starts at E+1; now just after E+3
    repeat (47) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL midframe_tx got %b want 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midframe_busy got %b want 0", busy); end
    check_status("midframe_rst", 32'h0000_0002);
    @(negedge clk);
    rst = 1'b0;
    start_rec();
    repeat (2*L) @(posedge clk);
    #2;
    rec = 1'b0;
    lows = 0; bsy = 0;
    for (int i = 0; i < tx_log.size(); i++) begin
      if (tx_log[i] !== 1'b1) lows++;
      if (busy_log[i] !== 1'b0) bsy++;
    end
    checks++;
    if (lows != 0 || bsy != 0) begin
      errors++;
      $display("FAIL queue_discarded got %0d low %0d busy samples want 0 0", lows, bsy);
    end
  endtask

  task automatic test_random_bursts();
    int n;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 4);
      start_rec();
      for (int i = 0; i < n; i++) send_byte(8'($urandom), 1'b1);
      repeat (n*L + 8) @(posedge clk);
      #2;
      rec = 1'b0;
      check_stream("random_burst");
    end
  endtask

  initial begin
    test_reset();
    test_single(8'h55, "single_55");
    test_single(8'($urandom), "single_rand");
    test_back_to_back();
    test_overflow();
    test_ovf_clear();
    test_full_push_pop();
    test_reset_midframe();
    test_random_bursts();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
